// File: rtl/main_mem_burst.sv
// Single-port main memory serving 1/4/8/16-word bursts with configurable read latency.
// Define MAIN_MEM_WRAP_BURST_EN for critical-word-first wrapping bursts; linear otherwise.
module main_mem_burst #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MEM_DEPTH    = 262144,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h8002_0000,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wren,
    input  logic [1:0]            acc_size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam int LAT_W      = $clog2(READ_LATENCY + 1);
    localparam int LAT_INIT   = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_beat;
    logic [3:0]            r_last;
    logic [LAT_W-1:0]      r_lat;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDX_W-1:0]      w_req_idx;
    logic [3:0]            w_req_last;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_go;
    logic [IDX_W-1:0]      w_beat_idx;
    logic [IDX_W-1:0]      w_mem_addr;
    logic                  w_mem_we;
    logic                  w_launch;

    assign w_offset   = addr - BASE_ADDR;
    assign w_word     = w_offset >> BYTE_SHIFT;
    assign w_req_idx  = w_word[IDX_W-1:0];
    assign w_in_range = (addr >= BASE_ADDR) && (w_word < ADDR_WIDTH'(MEM_DEPTH));
    assign w_accept   = enable && (r_state == IDLE);
    assign w_go       = w_accept && w_in_range;

    always_comb begin
        case (acc_size)
            2'b00:   w_req_last = 4'd0;
            2'b01:   w_req_last = 4'd3;
            2'b10:   w_req_last = 4'd7;
            default: w_req_last = 4'd15;
        endcase
    end

`ifdef MAIN_MEM_WRAP_BURST_EN
    logic [IDX_W-1:0] w_mask;
    assign w_mask     = IDX_W'(r_last);
    // Beats stay inside the N-aligned block, starting at the requested word.
    assign w_beat_idx = (r_idx & ~w_mask) | ((r_idx + IDX_W'(r_beat)) & w_mask);
`else
    assign w_beat_idx = r_idx + IDX_W'(r_beat);
`endif

    // NOTE: non-blocking assignments for every register so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = w_beat_idx;
        w_launch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    if (wren) begin
                        w_mem_we   = 1'b1;
                        w_mem_addr = w_req_idx;
                        if (w_req_last != 4'd0) w_next_state = WR_BURST;
                    end else if (READ_LATENCY > 1) begin
                        w_next_state = RD_WAIT;
                    end else begin
                        w_next_state = RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                w_mem_we = 1'b1;
                if (r_beat == r_last) w_next_state = IDLE;
            end
            RD_WAIT: begin
                if (r_lat == '0) w_next_state = RD_BURST;
            end
            RD_BURST: begin
                w_launch = 1'b1;
                if (r_beat == r_last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        // A reset edge aborts the burst before the pending beat lands.
        if (reset) w_mem_we = 1'b0;
    end

    // NOTE: the array has no reset so the loaded program image survives a reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) r_mem[w_mem_addr] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_beat     <= '0;
            r_last     <= '0;
            r_lat      <= '0;
        end else begin
            r_rd_valid <= w_launch;
            r_err      <= w_accept && !w_in_range;
            if (w_launch) r_data_out <= r_mem[w_beat_idx];
            if (w_go) begin
                r_idx  <= w_req_idx;
                r_last <= w_req_last;
                r_beat <= wren ? 4'd1 : 4'd0;
                r_lat  <= LAT_W'(LAT_INIT);
            end else begin
                if (r_state == WR_BURST || r_state == RD_BURST) r_beat <= r_beat + 4'd1;
                if (r_state == RD_WAIT) r_lat <= r_lat - 1'b1;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state != IDLE);
    assign err      = r_err;

endmodule

// File: tb/tb_main_mem_burst.sv
// Self-checking bench for main_mem_burst: one instance with READ_LATENCY 1, one with 3.
// Read data is scoreboarded per instance; timing of busy/rd_valid/err is checked per cycle.
module tb_main_mem_burst;

    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam int          DEPTH = 4096;

    typedef logic [31:0] burst_t [16];
    typedef struct { logic [31:0] a; logic [31:0] d; } single_t;
    typedef struct { logic wr; logic [31:0] a; } range_t;

    logic        clock = 1'b0;
    logic        reset, en1, en3, wren;
    logic [1:0]  acc_size;
    logic [31:0] addr, data_in;
    logic [31:0] data_out1, data_out3;
    logic        rd_valid1, busy1, err1, rd_valid3, busy3, err3;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q1[$];
    logic [31:0] q3[$];

    always #5 clock = ~clock;

    main_mem_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
                     .BASE_ADDR(BASE), .READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .enable(en1), .wren(wren), .acc_size(acc_size),
        .addr(addr), .data_in(data_in), .data_out(data_out1), .rd_valid(rd_valid1),
        .busy(busy1), .err(err1));

    main_mem_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
                     .BASE_ADDR(BASE), .READ_LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .enable(en3), .wren(wren), .acc_size(acc_size),
        .addr(addr), .data_in(data_in), .data_out(data_out3), .rd_valid(rd_valid3),
        .busy(busy3), .err(err3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_en(input bit sel3, input logic v);
        if (sel3) en3 = v;
        else      en1 = v;
    endtask

    function automatic int blen(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Scoreboard: every valid read beat must match the oldest expected word.
    always @(negedge clock) begin
        if (rd_valid1) begin
            if (q1.size() == 0) check("dut1 unexpected beat", rd_valid1, 1'b0);
            else                check("dut1 rd_data", data_out1, q1.pop_front());
        end
        if (rd_valid3) begin
            if (q3.size() == 0) check("dut3 unexpected beat", rd_valid3, 1'b0);
            else                check("dut3 rd_data", data_out3, q3.pop_front());
        end
    end

    task automatic write_burst(input bit sel3, input logic [31:0] a, input logic [1:0] sz,
                               input burst_t d);
        int n = blen(sz);
        wren = 1'b1; acc_size = sz; addr = a; data_in = d[0];
        set_en(sel3, 1'b1);
        tick();
        set_en(sel3, 1'b0);
        for (int k = 1; k < n; k++) begin
            check($sformatf("wr busy beat%0d", k), sel3 ? busy3 : busy1, 1'b1);
            data_in = d[k];
            tick();
        end
        check("wr busy end", sel3 ? busy3 : busy1, 1'b0);
        wren = 1'b0;
    endtask

    task automatic read_burst(input bit sel3, input logic [31:0] a, input logic [1:0] sz,
                              input burst_t e, input bit poke);
        int n  = blen(sz);
        int rl = sel3 ? 3 : 1;
        wren = 1'b0; acc_size = sz; addr = a;
        for (int k = 0; k < n; k++) begin
            if (sel3) q3.push_back(e[k]);
            else      q1.push_back(e[k]);
        end
        set_en(sel3, 1'b1);
        tick();
        set_en(sel3, 1'b0);
        for (int c = 0; c <= rl + n; c++) begin
            if (c > 0) tick();
            check($sformatf("rd_valid c%0d", c), sel3 ? rd_valid3 : rd_valid1,
                  (c >= rl) && (c < rl + n));
            check($sformatf("rd busy c%0d", c), sel3 ? busy3 : busy1, c < rl + n - 1);
            if (poke && c == 2) begin
                wren = 1'b1; data_in = 32'hDEAD_BEEF;
                set_en(sel3, 1'b1);
            end else if (poke && c == 3) begin
                set_en(sel3, 1'b0);
                wren = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        single_t sv[4];
        range_t  rv[5];
        burst_t  d, p, qd, e;

        reset = 1'b1; en1 = 1'b0; en3 = 1'b0; wren = 1'b0;
        acc_size = 2'b00; addr = BASE; data_in = '0;
        d = '{default: '0}; p = '{default: '0}; qd = '{default: '0}; e = '{default: '0};

        repeat (3) tick();
        check("rst data_out1", data_out1, 32'h0);
        check("rst rd_valid1", rd_valid1, 1'b0);
        check("rst busy1", busy1, 1'b0);
        check("rst err1", err1, 1'b0);
        check("rst busy3", busy3, 1'b0);
        check("rst rd_valid3", rd_valid3, 1'b0);
        reset = 1'b0;
        tick();

        // Single words: first entry is the program's first instruction.
        sv[0] = '{BASE,                32'h27BD_FFD0};
        sv[1] = '{BASE + 32'h3FFC,     32'h1357_9BDF};
        sv[2] = '{BASE + 32'h123,      32'hA5A5_5A5A};
        sv[3] = '{BASE + 32'h200,      32'h0F0F_F0F0};
        for (int i = 0; i < 4; i++) begin
            d[0] = sv[i].d;
            write_burst(1'b0, sv[i].a, 2'b00, d);
        end
        for (int i = 0; i < 4; i++) begin
            e[0] = sv[i].d;
            read_burst(1'b0, sv[i].a, 2'b00, e, 1'b0);
        end
        e[0] = 32'hA5A5_5A5A;
        read_burst(1'b0, BASE + 32'h120, 2'b00, e, 1'b0);

        // 4-word burst at word 4.
        for (int k = 0; k < 4; k++) d[k] = 32'hA000_0000 + k;
        write_burst(1'b0, BASE + 32'h10, 2'b01, d);
        read_burst(1'b0, BASE + 32'h10, 2'b01, d, 1'b0);

        // 16-word burst on the latency-3 instance, with a write poked while busy.
        for (int k = 0; k < 16; k++) p[k] = 32'h4000_0000 + 32'h111 * k;
        write_burst(1'b1, BASE + 32'h800, 2'b11, p);
        read_burst(1'b1, BASE + 32'h800, 2'b11, p, 1'b1);
        e[0] = p[0];
        read_burst(1'b1, BASE + 32'h800, 2'b00, e, 1'b0);

        // Out-of-range requests.
        rv[0] = '{1'b1, 32'h8000_0000};
        rv[1] = '{1'b0, 32'h8000_0000};
        rv[2] = '{1'b1, BASE + DEPTH * 4};
        rv[3] = '{1'b0, BASE + DEPTH * 4};
        rv[4] = '{1'b0, BASE - 32'h4};
        for (int i = 0; i < 5; i++) begin
            wren = rv[i].wr; addr = rv[i].a; acc_size = 2'b11;
            data_in = 32'hBAD0_0000 + i;
            en1 = 1'b1;
            tick();
            en1 = 1'b0;
            check($sformatf("range%0d err", i), err1, 1'b1);
            check($sformatf("range%0d busy", i), busy1, 1'b0);
            check($sformatf("range%0d rd_valid", i), rd_valid1, 1'b0);
            tick();
            check($sformatf("range%0d err drop", i), err1, 1'b0);
            check($sformatf("range%0d rd_valid2", i), rd_valid1, 1'b0);
        end
        wren = 1'b0;
        e[0] = 32'h27BD_FFD0;
        read_burst(1'b0, BASE, 2'b00, e, 1'b0);
        e[0] = 32'h1357_9BDF;
        read_burst(1'b0, BASE + 32'h3FFC, 2'b00, e, 1'b0);

        // Reset during a 16-word write after beat 5.
        for (int k = 0; k < 16; k++) begin
            d[k]  = 32'h5000_0000 + k;
            qd[k] = 32'h6000_0000 + k;
        end
        write_burst(1'b0, BASE + 32'h400, 2'b11, d);
        wren = 1'b1; acc_size = 2'b11; addr = BASE + 32'h400; data_in = qd[0];
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            data_in = qd[k];
            tick();
        end
        data_in = qd[6];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wren = 1'b0;
        check("midrst busy", busy1, 1'b0);
        check("midrst rd_valid", rd_valid1, 1'b0);
        for (int k = 0; k < 16; k++) e[k] = (k <= 5) ? qd[k] : d[k];
        read_burst(1'b0, BASE + 32'h400, 2'b11, e, 1'b0);

        // Burst starting mid-block at word 2.
        for (int k = 0; k < 8; k++) d[k] = k;
        write_burst(1'b0, BASE, 2'b10, d);
`ifdef MAIN_MEM_WRAP_BURST_EN
        e[0] = 2; e[1] = 3; e[2] = 0; e[3] = 1;
`else
        e[0] = 2; e[1] = 3; e[2] = 4; e[3] = 5;
`endif
        read_burst(1'b0, BASE + 32'h8, 2'b01, e, 1'b0);

        repeat (3) tick();
        check("dut1 scoreboard drained", q1.size(), 0);
        check("dut3 scoreboard drained", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
